// File: rtl/hc595_serializer.sv
// Parallel-to-serial front end for a 74HC595-style chain: accepts a word over
// ready/valid, shifts it out on ser/srclk, then issues one rclk latch pulse.
module hc595_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             done
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             div_end;
  logic             ser_d;
  logic             done_d;

  assign div_end = (div_q == DIV_LAST);

  // State, datapath and output registers; outputs are decoded from next state
  // so they line up with the phase they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      ready   <= 1'b1;
      ser     <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ready   <= (state_d == S_IDLE);
      ser     <= ser_d;
      srclk   <= (state_d == S_HIGH);
      rclk    <= (state_d == S_LATCH);
      done    <= done_d;
    end
  end

  // Next-state logic: each phase lasts DIV cycles, bits advance on HIGH->LOW.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    ser_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_LOW;
          sr_d    = data_in;
          bit_d   = '0;
          div_d   = '0;
        end
      end

      S_LOW: begin
        if (div_end) begin
          state_d = S_HIGH;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_HIGH: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_LOW;
            sr_d    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_LATCH: begin
        if (div_end) begin
          state_d = S_IDLE;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ser only moves when entering LOW, so it is stable across every srclk rise.
    if ((state_d == S_LOW) || (state_d == S_HIGH)) begin
      ser_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end
  end

endmodule

// File: tb/tb_hc595_serializer.sv
// Bench for hc595_serializer: per-cycle comparison against a phase-arithmetic
// model, plus behavioural 74HC595 shift/latch registers on each instance.
`timescale 1ns/1ps
module tb_hc595_serializer;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 2;
  localparam int unsigned BUSY = (2 * W + 1) * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: WIDTH=8, DIV=2, MSB first
  logic [7:0] data_a;
  logic load_a, ready_a, ser_a, srclk_a, rclk_a, done_a;
  // Instance B: WIDTH=8, DIV=2, LSB first
  logic [7:0] data_b;
  logic load_b, ready_b, ser_b, srclk_b, rclk_b, done_b;
  // Instance C: WIDTH=4, DIV=1, MSB first (loopback)
  logic [3:0] data_c;
  logic load_c, ready_c, ser_c, srclk_c, rclk_c, done_c;

  hc595_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .data_in(data_a), .load(load_a), .ready(ready_a),
    .ser(ser_a), .srclk(srclk_a), .rclk(rclk_a), .done(done_a));

  hc595_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .data_in(data_b), .load(load_b), .ready(ready_b),
    .ser(ser_b), .srclk(srclk_b), .rclk(rclk_b), .done(done_b));

  hc595_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .data_in(data_c), .load(load_c), .ready(ready_c),
    .ser(ser_c), .srclk(srclk_c), .rclk(rclk_c), .done(done_c));

  // Behavioural downstream shift registers and storage latches
  logic [7:0] sh_a = '0, q_a = '0, sh_b = '0, q_b = '0;
  logic [3:0] sh_c = '0, q_c = '0;
  int rises_a = 0, rclk_cnt_a = 0;
  logic bits_a[$];
  logic bits_b[$];

  always @(posedge srclk_a) begin
    sh_a = {sh_a[6:0], ser_a};
    bits_a.push_back(ser_a);
    rises_a = rises_a + 1;
  end
  always @(posedge rclk_a) begin
    q_a = sh_a;
    rclk_cnt_a = rclk_cnt_a + 1;
  end
  always @(posedge srclk_b) begin
    sh_b = {sh_b[6:0], ser_b};
    bits_b.push_back(ser_b);
  end
  always @(posedge rclk_b) q_b = sh_b;
  always @(posedge srclk_c) sh_c = {sh_c[2:0], ser_c};
  always @(posedge rclk_c) q_c = sh_c;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {ready, ser, srclk, rclk, done} o cycles after the accept edge.
  function automatic logic [4:0] model(input int unsigned wd, input int unsigned dv,
                                       input bit msb, input logic [7:0] d,
                                       input int unsigned o);
    int unsigned busy, ph, k, idx;
    logic rdy, s, sc, rc, dn;
    busy = (2 * wd + 1) * dv;
    rdy = 1'b0; s = 1'b0; sc = 1'b0; rc = 1'b0; dn = 1'b0;
    if (o == 0 || o > busy) begin
      rdy = 1'b1;
      dn  = (o == busy + 1);
    end else begin
      ph = (o - 1) / dv;
      if (ph < 2 * wd) begin
        k   = ph / 2;
        idx = msb ? (wd - 1 - k) : k;
        s   = d[idx];
        sc  = (ph % 2) == 1;
      end else begin
        rc = 1'b1;
      end
    end
    return {rdy, s, sc, rc, dn};
  endfunction

  // One transfer on instance A with full per-cycle checking. Returns in the
  // done cycle (#1 after its edge); with chain=1 load stays high for a
  // zero-gap follow-on accept of d_next.
  task automatic xfer_a(input logic [7:0] d, input bit chain, input logic [7:0] d_next,
                        input string tag);
    logic [4:0] got;
    check({tag, " ready before accept"}, 32'(ready_a), 32'd1);
    data_a = d;
    load_a = 1'b1;
    @(posedge clk); #1;
    if (!chain) load_a = 1'b0;
    for (int unsigned o = 1; o <= BUSY + 1; o++) begin
      got = {ready_a, ser_a, srclk_a, rclk_a, done_a};
      check($sformatf("%s o=%0d {rdy,ser,srclk,rclk,done}", tag, o),
            32'(got), 32'(model(W, D, 1'b1, d, o)));
      if (o == 3) data_a = 8'h00;
      if (o == BUSY) data_a = d_next;
      if (o <= BUSY) begin
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_seq;   // ser at successive srclk rises, first bit in [7]
    logic [7:0] exp_q;     // downstream latched word
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [7:0] seq;
    logic [7:0] last_word;
    logic [7:0] rnd[7];
    bit chain_r[7];
    int r0, rc0, cyc;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[2] = '{8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{8'h81, 8'h81, 8'h81};

    data_a = '0; load_a = 1'b0;
    data_b = '0; load_b = 1'b0;
    data_c = '0; load_c = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset A outputs", 32'({ready_a, ser_a, srclk_a, rclk_a, done_a}), 32'(5'b10000));
    check("reset B outputs", 32'({ready_b, ser_b, srclk_b, rclk_b, done_b}), 32'(5'b10000));
    check("reset C outputs", 32'({ready_c, ser_c, srclk_c, rclk_c, done_c}), 32'(5'b10000));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven single transfers
    for (int i = 0; i < 5; i++) begin
      bits_a.delete();
      r0 = rises_a;
      xfer_a(tbl[i].data, 1'b0, 8'h00, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d srclk rises", i), 32'(rises_a - r0), 32'd8);
      check($sformatf("tbl%0d latched", i), 32'(q_a), 32'(tbl[i].exp_q));
      check($sformatf("tbl%0d bit count", i), 32'(bits_a.size()), 32'd8);
      seq = tbl[i].exp_seq;
      for (int k = 0; k < 8 && k < bits_a.size(); k++)
        check($sformatf("tbl%0d ser at rise %0d", i, k), 32'(bits_a[k]), 32'(seq[7-k]));
    end
    @(posedge clk); #1;
    check("idle after table", 32'({ready_a, ser_a, srclk_a, rclk_a, done_a}), 32'(5'b10000));

    // Busy and back-to-back with load held high
    bits_a.delete();
    r0 = rises_a;
    xfer_a(8'h3C, 1'b1, 8'hFF, "b2b0");
    check("b2b0 latched", 32'(q_a), 32'h3C);
    check("b2b0 rises", 32'(rises_a - r0), 32'd8);
    xfer_a(8'hFF, 1'b0, 8'h00, "b2b1");
    check("b2b1 latched", 32'(q_a), 32'hFF);
    check("b2b total rises", 32'(rises_a - r0), 32'd16);
    if (bits_a.size() == 16) begin
      seq = 8'h3C;
      for (int k = 0; k < 8; k++)
        check($sformatf("b2b0 ser at rise %0d", k), 32'(bits_a[k]), 32'(seq[7-k]));
    end else begin
      check("b2b bit count", 32'(bits_a.size()), 32'd16);
    end

    // Randomized transfers, some chained
    for (int i = 0; i < 7; i++) begin
      rnd[i] = 8'($urandom);
      chain_r[i] = (i < 6) && ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 7; i++) begin
      xfer_a(rnd[i], chain_r[i], (i < 6) ? rnd[i+1] : 8'h00, $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d latched", i), 32'(q_a), 32'(rnd[i]));
      if (!chain_r[i]) begin
        @(posedge clk); #1;
      end
    end
    last_word = rnd[6];

    // LSB first on instance B
    bits_b.delete();
    data_b = 8'h01; load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    data_b = 8'hFE;
    cyc = 0;
    while (!done_b && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("lsb done seen", 32'(done_b), 32'd1);
    check("lsb done latency", 32'(cyc), 32'(BUSY));
    check("lsb bit count", 32'(bits_b.size()), 32'd8);
    for (int k = 0; k < 8 && k < bits_b.size(); k++)
      check($sformatf("lsb ser at rise %0d", k), 32'(bits_b[k]),
            32'(model(W, D, 1'b0, 8'h01, 1 + 2 * k * D) >> 3) & 32'd1);
    check("lsb latched", 32'(q_b), 32'h80);

    // Loopback on instance C
    data_c = 4'b1011; load_c = 1'b1;
    @(posedge clk); #1;
    load_c = 1'b0;
    data_c = 4'b0000;
    check("loop ready low", 32'(ready_c), 32'd0);
    cyc = 0;
    while (!done_c && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("loop done seen", 32'(done_c), 32'd1);
    check("loop done latency", 32'(cyc), 32'd9);
    check("loop q4..q1", 32'(q_c), 32'(4'b1011));

    // Abort after the third srclk rise of an 8'hFF transfer
    @(posedge clk); #1;
    r0 = rises_a;
    rc0 = rclk_cnt_a;
    data_a = 8'hFF; load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0;
    cyc = 0;
    while (rises_a < r0 + 3 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("abort third rise reached", 32'(rises_a - r0), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("abort async outputs", 32'({ready_a, ser_a, srclk_a, rclk_a, done_a}), 32'(5'b10000));
    repeat (4) @(posedge clk);
    #1;
    check("abort held outputs", 32'({ready_a, ser_a, srclk_a, rclk_a, done_a}), 32'(5'b10000));
    check("abort no rclk pulse", 32'(rclk_cnt_a - rc0), 32'd0);
    check("abort latched retained", 32'(q_a), 32'(last_word));
    @(negedge clk) rst = 1'b0;
    bits_a.delete();
    xfer_a(8'h81, 1'b0, 8'h00, "post");
    check("post latched", 32'(q_a), 32'h81);
    check("post rclk pulses", 32'(rclk_cnt_a - rc0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
